// File: rtl/dlx_mem_arbiter_pkg.sv
// Shared types and defaults for the DLX single-port RAM arbiter.
package dlx_mem_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int DEF_DEPTH      = 64;
   localparam int DEF_MAX_DBURST = 4;
endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Requester (I/D) and RAM side signals of the DLX memory arbiter.
interface dlx_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req_i;
   logic [ADDR_W-1:0] i_adr_i;
   logic              i_ack_o;
   logic [DATA_W-1:0] i_data_o;
   logic              i_err_o;
   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_adr_i;
   logic [DATA_W-1:0] d_data_i;
   logic              d_ack_o;
   logic [DATA_W-1:0] d_data_o;
   logic              d_err_o;
   logic [ADDR_W-1:0] ram_adr_o;
   logic              ram_we_o;
   logic [DATA_W-1:0] ram_data_o;
   logic [DATA_W-1:0] ram_data_i;
   logic              busy_o;

   modport slave (
      input  i_req_i, i_adr_i, d_req_i, d_we_i, d_adr_i, d_data_i, ram_data_i,
      output i_ack_o, i_data_o, i_err_o, d_ack_o, d_data_o, d_err_o,
             ram_adr_o, ram_we_o, ram_data_o, busy_o
   );

   modport master (
      output i_req_i, i_adr_i, d_req_i, d_we_i, d_adr_i, d_data_i, ram_data_i,
      input  i_ack_o, i_data_o, i_err_o, d_ack_o, d_data_o, d_err_o,
             ram_adr_o, ram_we_o, ram_data_o, busy_o
   );
endinterface

// File: rtl/dlx_mem_arbiter_pick.sv
// D-over-I winner select with a saturating starvation counter that forces I in.
module dlx_mem_arb_pick
   import dlx_mem_pkg::*;
#(
   parameter int MAX_DBURST = DEF_MAX_DBURST
) (
   input  logic clk_i,
   input  logic reset,
   input  logic i_req,
   input  logic d_req,
   input  logic grant_strobe,
   input  logic idle,
   output logic winner_id
);
   localparam int CW = $clog2(MAX_DBURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DBURST);

   logic [CW-1:0] starve_cnt;

   assign winner_id = (d_req && !(i_req && starve_cnt == CNT_MAX)) ? REQ_D : REQ_I;

   // An idle cycle without a fetch pending means I is not waiting any more.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (idle && !i_req) begin
         starve_cnt <= '0;
      end else if (grant_strobe) begin
         if (winner_id == REQ_I)
            starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/dlx_mem_arbiter.sv
// Shares one synchronous RAM between DLX fetch (I) and load/store (D) ports.
module dlx_mem_arbiter
   import dlx_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int MAX_DBURST = DEF_MAX_DBURST
) (
   input logic              clk_i,
   input logic              reset,
   dlx_mem_arbiter_if.slave bus
);
   state_t            state;
   logic              grant, oor, rd_ok;
   logic              winner_id, any_req, idle, in_range, is_store;
   logic [ADDR_W-1:0] sel_adr;

   assign any_req  = bus.i_req_i | bus.d_req_i;
   assign idle     = (state == IDLE);
   assign sel_adr  = (winner_id == REQ_D) ? bus.d_adr_i : bus.i_adr_i;
   assign in_range = sel_adr < ADDR_W'(DEPTH);
   assign is_store = (winner_id == REQ_D) && bus.d_we_i;

   dlx_mem_arb_pick #(.MAX_DBURST(MAX_DBURST)) u_pick (
      .clk_i        (clk_i),
      .reset        (reset),
      .i_req        (bus.i_req_i),
      .d_req        (bus.d_req_i),
      .grant_strobe (idle && any_req),
      .idle         (idle),
      .winner_id    (winner_id)
   );

   // RAM read data arrives in RESP, so it is passed through while ack is high.
   assign bus.i_data_o = (bus.i_ack_o && rd_ok) ? bus.ram_data_i : '0;
   assign bus.d_data_o = (bus.d_ack_o && rd_ok) ? bus.ram_data_i : '0;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state          <= IDLE;
         grant          <= REQ_I;
         oor            <= 1'b0;
         rd_ok          <= 1'b0;
         bus.ram_adr_o  <= '0;
         bus.ram_we_o   <= 1'b0;
         bus.ram_data_o <= '0;
         bus.i_ack_o    <= 1'b0;
         bus.i_err_o    <= 1'b0;
         bus.d_ack_o    <= 1'b0;
         bus.d_err_o    <= 1'b0;
         bus.busy_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               state          <= ISSUE;
               bus.busy_o     <= 1'b1;
               grant          <= winner_id;
               oor            <= !in_range;
               rd_ok          <= in_range && !is_store;
               bus.ram_adr_o  <= sel_adr;
               bus.ram_we_o   <= is_store && in_range;
               bus.ram_data_o <= (winner_id == REQ_D) ? bus.d_data_i : DATA_W'(0);
            end
            ISSUE: begin
               state          <= RESP;
               bus.ram_adr_o  <= '0;
               bus.ram_we_o   <= 1'b0;
               bus.ram_data_o <= '0;
               bus.i_ack_o    <= (grant == REQ_I);
               bus.d_ack_o    <= (grant == REQ_D);
               bus.i_err_o    <= (grant == REQ_I) && oor;
               bus.d_err_o    <= (grant == REQ_D) && oor;
            end
            RESP: begin
               state       <= IDLE;
               bus.busy_o  <= 1'b0;
               bus.i_ack_o <= 1'b0;
               bus.d_ack_o <= 1'b0;
               bus.i_err_o <= 1'b0;
               bus.d_err_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
